// File: rtl/trng_pkg.sv
// Shared types and default widths for the TRNG sequencer.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    COLLECT,
    DELIVER,
    FAULT
  } trng_state_t;

  localparam int TRNG_DATA_WIDTH   = 32;
  localparam int TRNG_LFSR_WIDTH   = 32;
  localparam int TRNG_RESEED_WORDS = 16;
  localparam int TRNG_REP_LIMIT    = 8;

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: counts consecutive equal whitened bits and
// flags the bit that brings the run length up to REP_LIMIT.
module trng_rep_test #(
  parameter int REP_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_val,
  output logic fail
);

  localparam int CW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(REP_LIMIT);

  logic [CW-1:0] cnt, cnt_n;
  logic          last;

  // Run length including the incoming bit; saturates at the limit.
  always_comb begin
    cnt_n = cnt;
    if (bit_vld) begin
      if (cnt == '0 || bit_val != last) cnt_n = CW'(1);
      else if (cnt != LIM)              cnt_n = cnt + 1'b1;
    end
  end

  assign fail = bit_vld && (cnt_n == LIM);

  // Run-length state; clr starts a fresh run after a (re)seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (bit_vld) begin
      cnt  <= cnt_n;
      last <= bit_val;
    end
  end

endmodule

// File: rtl/trng_seq_ctrl.sv
// TRNG sequencer: seeds the LFSR, collects one whitened bit per TMW window,
// packs DATA_WIDTH-bit words onto a valid/ready port and reseeds the LFSR
// from its own delivered output every RESEED_WORDS words.
// Optional build macro: TRNG_HEALTH_EN adds a repetition-count health test
// and a sticky FAULT state left only through clr_fault_i.
module trng_seq_ctrl
  import trng_pkg::*;
#(
  parameter int DATA_WIDTH   = TRNG_DATA_WIDTH,
  parameter int LFSR_WIDTH   = TRNG_LFSR_WIDTH,
  parameter int RESEED_WORDS = TRNG_RESEED_WORDS,
  parameter int REP_LIMIT    = TRNG_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic                  tmw_done_i,
  input  logic                  ro_bit_i,
  input  logic                  lfsr_bit_i,
  output logic                  request_o,
  output logic                  seed_we_o,
  output logic [LFSR_WIDTH-1:0] seed_o,
  output logic [DATA_WIDTH-1:0] rnd_data_o,
  output logic                  rnd_valid_o,
  input  logic                  rnd_ready_i,
  output logic                  busy_o,
  output logic                  fault_o,
  input  logic                  clr_fault_i
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int WCW = (RESEED_WORDS > 0) ? $clog2(RESEED_WORDS + 1) : 1;
  localparam int RW_LAST_I = (RESEED_WORDS > 0) ? RESEED_WORDS - 1 : 0;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [WCW-1:0] RW_LAST  = WCW'(RW_LAST_I);

  trng_state_t           state;
  logic [DATA_WIDTH-1:0] shreg, sh_next;
  logic [BCW-1:0]        bit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic [LFSR_WIDTH-1:0] reseed_val;
  logic                  b;
  logic                  reseed_due, word_wrap;

  assign b       = ro_bit_i ^ lfsr_bit_i;
  assign sh_next = {shreg[DATA_WIDTH-2:0], b};

  // With reseeding disabled the word counter simply stays at zero.
  assign reseed_due = (RESEED_WORDS != 0) && (word_cnt == RW_LAST);
  assign word_wrap  = (RESEED_WORDS == 0) || (word_cnt == RW_LAST);

  // Delivered word becomes the next seed, zero-extended or truncated.
  always_comb begin
    reseed_val = '0;
    for (int i = 0; i < LFSR_WIDTH && i < DATA_WIDTH; i++) reseed_val[i] = rnd_data_o[i];
  end

`ifdef TRNG_HEALTH_EN
  logic rep_fail;

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SEED),
    .bit_vld (state == COLLECT && run_i && tmw_done_i),
    .bit_val (b),
    .fail    (rep_fail)
  );
`else
  localparam int unused_rep_limit = REP_LIMIT;
  logic unused_clr_fault;
  assign unused_clr_fault = clr_fault_i;
`endif

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      request_o   <= 1'b0;
      seed_we_o   <= 1'b0;
      seed_o      <= '0;
      rnd_data_o  <= '0;
      rnd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      fault_o     <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
    end else begin
      // Seed strobe is a single cycle; seed_o only carries data alongside it.
      seed_we_o <= 1'b0;
      seed_o    <= '0;
      case (state)
        IDLE: begin
          if (run_i) begin
            state     <= SEED;
            seed_we_o <= 1'b1;
            seed_o    <= seed_i;
            busy_o    <= 1'b1;
          end
        end
        SEED: begin
          // The strobe has already gone out; a dropped run_i just ends here.
          if (run_i) begin
            state     <= COLLECT;
            request_o <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        COLLECT: begin
          if (!run_i) begin
            // Partial word is discarded.
            state     <= IDLE;
            request_o <= 1'b0;
            busy_o    <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
          end else if (tmw_done_i) begin
`ifdef TRNG_HEALTH_EN
            if (rep_fail) begin
              state     <= FAULT;
              request_o <= 1'b0;
              fault_o   <= 1'b1;
              shreg     <= '0;
              bit_cnt   <= '0;
            end else
`endif
            if (bit_cnt == BIT_LAST) begin
              state       <= DELIVER;
              request_o   <= 1'b0;
              rnd_data_o  <= sh_next;
              rnd_valid_o <= 1'b1;
              shreg       <= '0;
              bit_cnt     <= '0;
            end else begin
              shreg   <= sh_next;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DELIVER: begin
          if (rnd_ready_i) begin
            rnd_valid_o <= 1'b0;
            word_cnt    <= word_wrap ? '0 : word_cnt + 1'b1;
            if (!run_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else if (reseed_due) begin
              state     <= SEED;
              seed_we_o <= 1'b1;
              seed_o    <= reseed_val;
            end else begin
              state     <= COLLECT;
              request_o <= 1'b1;
              bit_cnt   <= '0;
            end
          end
        end
`ifdef TRNG_HEALTH_EN
        FAULT: begin
          if (clr_fault_i) begin
            state   <= IDLE;
            fault_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          request_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Scoreboard bench for trng_seq_ctrl (DATA_WIDTH=8, RESEED_WORDS=2, REP_LIMIT=4).
// Expected words and seeds are queued by the stimulus; a negedge monitor
// pops them on every handshake / seed strobe.
module tb_trng_seq_ctrl;
  localparam int DW = 8;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_i = 1'b0;
  logic [LW-1:0] seed_i = '0;
  logic          tmw_done_i = 1'b0;
  logic          ro_bit_i = 1'b0;
  logic          lfsr_bit_i = 1'b0;
  logic          rnd_ready_i = 1'b0;
  logic          clr_fault_i = 1'b0;
  logic          request_o, seed_we_o, rnd_valid_o, busy_o, fault_o;
  logic [LW-1:0] seed_o;
  logic [DW-1:0] rnd_data_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_data[$];
  logic [LW-1:0] exp_seed[$];
  logic          seed_we_d = 1'b0;

  always #5 clk = ~clk;

  trng_seq_ctrl #(.DATA_WIDTH(DW), .LFSR_WIDTH(LW), .RESEED_WORDS(2), .REP_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .seed_i(seed_i), .tmw_done_i(tmw_done_i),
    .ro_bit_i(ro_bit_i), .lfsr_bit_i(lfsr_bit_i), .request_o(request_o),
    .seed_we_o(seed_we_o), .seed_o(seed_o), .rnd_data_o(rnd_data_o),
    .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i), .busy_o(busy_o),
    .fault_o(fault_o), .clr_fault_i(clr_fault_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on seed strobes and data handshakes.
  always @(negedge clk) begin
    if (seed_we_o) begin
      chk("seed_pulse_width", seed_we_d, 1'b0);
      if (exp_seed.size() == 0) chk("seed_unexpected", seed_o, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("seed_value", seed_o, exp_seed.pop_front());
    end
    seed_we_d = seed_we_o;
    if (rnd_valid_o && rnd_ready_i) begin
      if (exp_data.size() == 0) chk("data_unexpected", rnd_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rnd_data", rnd_data_o, exp_data.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_request"}, request_o, 0);
    chk({tag, "_seed_we"}, seed_we_o, 0);
    chk({tag, "_seed"}, seed_o, 0);
    chk({tag, "_data"}, rnd_data_o, 0);
    chk({tag, "_valid"}, rnd_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_fault"}, fault_o, 0);
  endtask

  // One TMW window ending with whitened bit b; lf chooses the LFSR half.
  task automatic send_bit(input logic bv, input logic lf);
    tmw_done_i = 1'b1;
    lfsr_bit_i = lf;
    ro_bit_i   = bv ^ lf;
    tick();
    tmw_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] bits, input logic [7:0] lf);
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i], lf[i]);
      if (i % 3 == 0) tick();
    end
  endtask

  task automatic start(input logic [LW-1:0] s);
    run_i  = 1'b1;
    seed_i = s;
    exp_seed.push_back(s);
    tick();
    tick();
  endtask

  task automatic deliver();
    int t = 0;
    while (!rnd_valid_o && t < 100) begin
      tick();
      t++;
    end
    chk("deliver_wait_valid", rnd_valid_o, 1);
    if (rnd_valid_o) begin
      rnd_ready_i = 1'b1;
      tick();
      rnd_ready_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 1: seed strobe at edge +1, request at edge +2
    run_i  = 1'b1;
    seed_i = 32'hA5A5_A5A5;
    exp_seed.push_back(32'hA5A5_A5A5);
    tick();
    chk("t1_seed_we", seed_we_o, 1);
    chk("t1_request_early", request_o, 0);
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_seed_we_drop", seed_we_o, 0);
    chk("t1_request", request_o, 1);

    // 2: b = 1,0,1,1,0,0,1,0 -> 0xB2, held 5 cycles with ready low
    exp_data.push_back(8'hB2);
    send_word(8'hB2, 8'h5C);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", rnd_valid_o, 1);
      chk("t2_hold_data", rnd_data_o, 8'hB2);
      chk("t2_hold_request", request_o, 0);
      tick();
    end
    deliver();
    chk("t2_after_valid", rnd_valid_o, 0);
    chk("t2_after_request", request_o, 1);

    // 3: second word triggers reseed with the delivered word
    exp_data.push_back(8'h69);
    exp_seed.push_back(32'h0000_0069);
    send_word(8'h69, 8'hA3);
    deliver();
    chk("t3_reseed_we", seed_we_o, 1);
    chk("t3_reseed_request", request_o, 0);
    tick();
    chk("t3_reseed_done", seed_we_o, 0);
    chk("t3_collect_request", request_o, 1);
    // word counter restarted: third word no reseed, fourth reseeds
    exp_data.push_back(8'hD6);
    send_word(8'hD6, 8'h0F);
    deliver();
    chk("t3_no_reseed", seed_we_o, 0);
    chk("t3_no_reseed_request", request_o, 1);
    exp_data.push_back(8'h4B);
    exp_seed.push_back(32'h0000_004B);
    send_word(8'h4B, 8'hF0);
    deliver();
    chk("t3_second_reseed", seed_we_o, 1);
    tick();

    // 4: run_i drops after 3 bits; restart collects a fresh word
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    run_i = 1'b0;
    tick();
    chk("t4_request", request_o, 0);
    chk("t4_busy", busy_o, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t4_no_valid", rnd_valid_o, 0);
      tick();
    end
    start(32'h1234_5678);
    chk("t4_restart_request", request_o, 1);
    exp_data.push_back(8'h5A);
    send_word(8'h5A, 8'hFF);
    deliver();

    // 5: reset during DELIVER drops the pending word
    send_word(8'hA6, 8'h00);
    chk("t5_valid_before_rst", rnd_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("t5_async");
    run_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_valid_after", rnd_valid_o, 0);
      chk("t5_busy_after", busy_o, 0);
    end

    // 6: four consecutive ones
    start(32'hDEAD_BEEF);
`ifdef TRNG_HEALTH_EN
    for (int k = 0; k < 4; k++) send_bit(1'b1, k[0]);
    chk("t6_fault", fault_o, 1);
    chk("t6_request", request_o, 0);
    chk("t6_valid", rnd_valid_o, 0);
    chk("t6_busy", busy_o, 1);
    run_i = 1'b0;
    tick();
    chk("t6_fault_sticky", fault_o, 1);
    clr_fault_i = 1'b1;
    tick();
    clr_fault_i = 1'b0;
    chk("t6_fault_clr", fault_o, 0);
    chk("t6_busy_clr", busy_o, 0);
`else
    exp_data.push_back(8'hF5);
    for (int k = 0; k < 4; k++) send_bit(1'b1, k[0]);
    chk("t6_no_fault", fault_o, 0);
    chk("t6_still_collect", request_o, 1);
    send_word_tail();
    deliver();
    run_i = 1'b0;
    chk("t6_fault_tied", fault_o, 0);
`endif
    tick();
    tick();
    chk("end_data_queue", exp_data.size(), 0);
    chk("end_seed_queue", exp_seed.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Remaining four bits 0,1,0,1 of the 0xF5 word.
  task automatic send_word_tail();
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
  endtask

endmodule
